// File: rtl/ro_freq_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ro_freq_counter_if
//  Description : Control/readout bundle between the tile control logic and
//                the ring-oscillator frequency counter.
//  Revision    : 1.0  initial release
// ============================================================================
interface ro_freq_counter_if #(
    parameter int GATE_W = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [GATE_W-1:0] gate_len;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    // Control/readout side: issues requests, reads back results
    modport master (
        output start, gate_len,
        input  busy, done, count, overflow
    );

    // Counter side
    modport slave (
        input  start, gate_len,
        output busy, done, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/ro_freq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ro_freq_counter
//  Description : Enables a ring oscillator, lets it settle, then counts its
//                rising edges over a programmable window of clk cycles.
//                Result (count, overflow) is held until the next accepted
//                start. Valid for f_ro < f_clk/2.
//  Revision    : 1.0  initial release
// ============================================================================
module ro_freq_counter #(
    parameter int GATE_W      = 16,
    parameter int CNT_W       = 16,
    parameter int SETTLE      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,      // active-high, synchronous
    input  wire logic             ro_out,     // asynchronous to clk
    output logic                  ro_activate,
    ro_freq_counter_if.slave      bus
);

    localparam int SET_W = $clog2(SETTLE + 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WARMUP = 2'd1;
    localparam logic [1:0] c_GATE   = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [SET_W-1:0] c_SETTLE_LOAD = SET_W'(SETTLE - 1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_delay;
    logic                   w_edge;

    logic [SET_W-1:0]       r_settle_cnt;
    logic [GATE_W-1:0]      r_gate_cnt;
    logic [GATE_W-1:0]      r_gate_len;
    logic [CNT_W-1:0]       r_count;
    logic                   r_overflow;

    logic                   w_accept;
    logic                   w_active_nxt;
    logic                   w_done_nxt;
    logic                   r_ro_activate;
    logic                   r_busy;
    logic                   r_done;

    // Synchroniser chain plus edge-detect delay flop; free-running in all states
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sync  <= '0;
            r_delay <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], ro_out};
            r_delay <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge   = r_sync[SYNC_STAGES-1] & ~r_delay;
    assign w_accept = (r_state == c_IDLE) && bus.start;

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only looked at in IDLE so it is never queued
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.gate_len != '0) ? c_WARMUP : c_DONE;
                end
            end
            c_WARMUP: begin
                if (r_settle_cnt == '0) begin
                    w_state_nxt = c_GATE;
                end
            end
            c_GATE: begin
                if (r_gate_cnt == '0) begin
                    w_state_nxt = c_DONE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the outputs can be flopped
    // without adding a cycle of latency
    always_comb begin
        w_active_nxt = (w_state_nxt == c_WARMUP) || (w_state_nxt == c_GATE);
        w_done_nxt   = (w_state_nxt == c_DONE);
    end

    // Registered outputs keep ro_activate glitch-free towards the oscillator
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_ro_activate <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_ro_activate <= w_active_nxt;
            r_busy        <= w_active_nxt;
            r_done        <= w_done_nxt;
        end
    end

    // Settle/gate down-counters and latched window length
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_settle_cnt <= '0;
            r_gate_cnt   <= '0;
            r_gate_len   <= '0;
        end else begin
            if (w_accept && (bus.gate_len != '0)) begin
                r_gate_len   <= bus.gate_len;
                r_settle_cnt <= c_SETTLE_LOAD;
            end else if (r_state == c_WARMUP) begin
                if (r_settle_cnt == '0) begin
                    r_gate_cnt <= r_gate_len - GATE_W'(1);
                end else begin
                    r_settle_cnt <= r_settle_cnt - SET_W'(1);
                end
            end else if ((r_state == c_GATE) && (r_gate_cnt != '0)) begin
                r_gate_cnt <= r_gate_cnt - GATE_W'(1);
            end
        end
    end

    // Edge counter: cleared on an accepted start, saturating, updated only in GATE
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if ((r_state == c_GATE) && w_edge) begin
            if (&r_count) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign ro_activate  = r_ro_activate;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ro_freq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ro_freq_counter
//  Description : Self-checking bench for ro_freq_counter. Two instances: a
//                16-bit counter and a 4-bit counter for saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ro_freq_counter;

    localparam int SETTLE = 8;

    typedef struct {
        int lo;
        int hi;
        int ovf;
        int done_at;
    } exp_t;

    logic clk;
    logic rst_n;
    logic osc_a;
    logic osc_b;
    logic ro_dead;
    logic ro_act_a;
    logic ro_act_b;
    logic ro_out_a;
    logic ro_out_b;

    int   n_tests;
    int   n_fail;
    int   cur_sel;
    exp_t sb[$];

    ro_freq_counter_if #(.GATE_W(16), .CNT_W(16)) ifa ();
    ro_freq_counter_if #(.GATE_W(16), .CNT_W(4))  ifb ();

    ro_freq_counter #(.GATE_W(16), .CNT_W(16), .SETTLE(SETTLE), .SYNC_STAGES(2)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .ro_out      (ro_out_a),
        .ro_activate (ro_act_a),
        .bus         (ifa)
    );

    ro_freq_counter #(.GATE_W(16), .CNT_W(4), .SETTLE(SETTLE), .SYNC_STAGES(2)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .ro_out      (ro_out_b),
        .ro_activate (ro_act_b),
        .bus         (ifb)
    );

    // 100 MHz clock; oscillators are free-running and off-grid, gated by ro_activate
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        osc_a = 1'b0;
        #3;
        forever #50 osc_a = ~osc_a;   // period 10 clk
    end

    initial begin
        osc_b = 1'b0;
        #7;
        forever #20 osc_b = ~osc_b;   // period 4 clk
    end

    assign ro_out_a = ro_act_a & osc_a & ~ro_dead;
    assign ro_out_b = ro_act_b & osc_b;

    logic        act_s;
    logic        busy_s;
    logic        done_s;
    logic        ovf_s;
    logic [15:0] cnt_s;

    always_comb begin
        act_s  = (cur_sel != 0) ? ro_act_b     : ro_act_a;
        busy_s = (cur_sel != 0) ? ifb.busy     : ifa.busy;
        done_s = (cur_sel != 0) ? ifb.done     : ifa.done;
        ovf_s  = (cur_sel != 0) ? ifb.overflow : ifa.overflow;
        cnt_s  = (cur_sel != 0) ? {12'd0, ifb.count} : ifa.count;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v, input logic [15:0] g);
        if (cur_sel != 0) begin
            ifb.start    = v;
            ifb.gate_len = g;
        end else begin
            ifa.start    = v;
            ifa.gate_len = g;
        end
    endtask

    // One measurement: push expectation, drive start, pop and compare on done
    task automatic run_meas(input int sel, input int g, input int lo, input int hi,
                            input int ovf, input int xs_gate, input bit xs_done,
                            input int hold);
        exp_t        e;
        int          ticks;
        int          act;
        bit          got;
        bit          bad_busy;
        bit          prev_busy;
        bit          bad;
        logic [15:0] cnt0;
        logic        ovf0;

        cur_sel   = sel;
        e.lo      = lo;
        e.hi      = hi;
        e.ovf     = ovf;
        e.done_at = (g == 0) ? 1 : SETTLE + g + 1;
        sb.push_back(e);

        set_start(1'b1, 16'(g));
        tick();
        ticks = 1;
        // gate_len changes after acceptance must not matter
        set_start(1'b0, 16'($urandom_range(1, 65535)));

        act       = 0;
        got       = 1'b0;
        bad_busy  = 1'b0;
        prev_busy = 1'b0;
        while (!got && (ticks < SETTLE + g + 40)) begin
            if (act_s) act++;
            if (busy_s != act_s) bad_busy = 1'b1;
            if (done_s) begin
                got = 1'b1;
            end else begin
                prev_busy = busy_s;
                set_start((ticks == xs_gate) ? 1'b1 : 1'b0, 16'(g));
                tick();
                ticks++;
            end
        end
        set_start(1'b0, 16'(g));

        e = sb.pop_front();
        if (!got) begin
            chk("done_timeout", 0, 1);
            return;
        end
        chk("done_at",        ticks, e.done_at);
        chk("act_cycles",     act, e.done_at - 1);
        chk("busy_eq_act",    bad_busy, 0);
        chk("busy_at_done",   busy_s, 0);
        chk("busy_before",    prev_busy, (g != 0) ? 1 : 0);
        chk("count_in_range", (int'(cnt_s) >= e.lo && int'(cnt_s) <= e.hi) ? 1 : 0, 1);
        if (int'(cnt_s) < e.lo || int'(cnt_s) > e.hi)
            $display("  count observed %0d range %0d..%0d", cnt_s, e.lo, e.hi);
        chk("overflow",       ovf_s, e.ovf);

        // Result must be held and no further measurement may start
        cnt0 = cnt_s;
        ovf0 = ovf_s;
        bad  = 1'b0;
        if (xs_done) set_start(1'b1, 16'(g));
        for (int i = 0; i < hold; i++) begin
            tick();
            set_start(1'b0, 16'(g));
            if (done_s || busy_s || act_s || (cnt_s != cnt0) || (ovf_s != ovf0)) bad = 1'b1;
        end
        chk("hold_result", bad, 0);
    endtask

    initial begin
        bit bad;

        n_tests  = 0;
        n_fail   = 0;
        cur_sel  = 0;
        ro_dead  = 1'b0;
        rst_n    = 1'b1;
        ifa.start = 1'b0; ifa.gate_len = '0;
        ifb.start = 1'b0; ifb.gate_len = '0;
        repeat (3) tick();

        chk("rst_activate", ro_act_a, 0);
        chk("rst_busy",     ifa.busy, 0);
        chk("rst_done",     ifa.done, 0);
        chk("rst_count",    ifa.count, 0);
        chk("rst_overflow", ifa.overflow, 0);
        rst_n = 1'b0;
        repeat (3) tick();

        // Nominal: period 10, window 100
        run_meas(0, 100, 9, 11, 0, 0, 1'b0, 10);
        // Zero-length window
        run_meas(0, 0, 0, 0, 0, 0, 1'b0, 10);
        // Saturation with 4-bit counter, held 50 cycles
        run_meas(1, 200, 15, 15, 1, 0, 1'b0, 50);
        // Extra starts in GATE and in DONE are ignored
        run_meas(0, 60, 5, 7, 0, SETTLE + 10, 1'b1, 30);

        // Reset mid-GATE aborts the measurement
        cur_sel = 0;
        set_start(1'b1, 16'd80);
        tick();
        set_start(1'b0, 16'd80);
        repeat (SETTLE + 20) tick();
        chk("pre_rst_count_nonzero", (ifa.count != 0) ? 1 : 0, 1);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        chk("abort_activate", ro_act_a, 0);
        chk("abort_busy",     ifa.busy, 0);
        chk("abort_count",    ifa.count, 0);
        chk("abort_done",     ifa.done, 0);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ifa.done || ifa.busy || ro_act_a) bad = 1'b1;
        end
        chk("abort_idle", bad, 0);
        run_meas(0, 50, 4, 6, 0, 0, 1'b0, 5);

        // Dead oscillator
        ro_dead = 1'b1;
        run_meas(0, 64, 0, 0, 0, 0, 1'b0, 5);
        ro_dead = 1'b0;

        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
